uart_echo_fifo: RTL
===================

Name: uart_echo_fifo

Overview:
Buffering stage between the UART receiver's byte output and the UART transmitter's byte input in the loopback path. Absorbs back-to-back received bytes in a circular FIFO. Launches each byte to the transmitter only when the transmitter is idle, so no byte is lost while a frame is in flight. Reports fill level and a sticky overflow flag for board-level LED indication.

Parameters:
PACK_SIZE, 8, width of each data byte; must match the UART wrapper.
DEPTH, 16, FIFO entries; power of two, at least 2.
CW, $clog2(DEPTH)+1, width of the count output (derived; do not override).

Ports:
clk  input  1  system clock (100 MHz)
rst_n  input  1  synchronous active-low reset
rx_byte_valid  input  1  one-cycle strobe: rx_byte_data holds a received byte
rx_byte_data  input  PACK_SIZE  received byte
tx_active  input  1  high while the transmitter is sending a frame
tx_done  input  1  one-cycle strobe at the end of a transmitter frame
tx_byte_valid  output  1  one-cycle launch strobe to the transmitter
tx_byte_data  output  PACK_SIZE  byte being launched; held stable until the next launch
fifo_count  output  CW  number of stored entries, 0..DEPTH
fifo_full  output  1  fifo_count == DEPTH
fifo_empty  output  1  fifo_count == 0
overflow  output  1  sticky: a byte was dropped because the FIFO was full
overflow_clr  input  1  clears overflow

Behaviour:
- Reset (rst_n low at a clk edge): wr_ptr, rd_ptr and count = 0; tx_byte_valid = 0; tx_byte_data = 0; overflow = 0; FSM = IDLE; fifo_empty = 1; fifo_full = 0. Stored data is don't-care.
- Reset mid-frame: the FIFO is flushed and the FSM returns to IDLE. The transmitter is reset by the same source, so no tx_done is awaited.
- Storage: DEPTH x PACK_SIZE register array. Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Push: on rx_byte_valid, the byte is written at wr_ptr and wr_ptr increments.
  - Accepted if count < DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped, pointers and count are unchanged, and overflow is set on the next edge.
- Pop: occurs only on the FSM transition IDLE->SEND.
- Count update rules:
  - push only: +1.
  - pop only: -1.
  - push and pop in the same cycle: unchanged.
- overflow: set wins over a simultaneous overflow_clr. Otherwise overflow_clr clears it on the next edge.
- FSM (registered):
  - IDLE: if !fifo_empty and !tx_active, go to SEND. Same edge: pop, tx_byte_data <= mem[rd_ptr], tx_byte_valid <= 1.
  - SEND: tx_byte_valid <= 0 and go to BUSY. Valid is therefore high for exactly one cycle.
  - BUSY: wait for tx_done, then go to IDLE. tx_active is ignored in BUSY.
  - A tx_done arriving in IDLE or SEND is ignored.
- Latency: a byte pushed into an empty FIFO with the transmitter idle (push edge at cycle N) gives tx_byte_valid high during cycle N+2.
- Back-to-back launch: the earliest next tx_byte_valid is 2 cycles after tx_done (BUSY->IDLE, then IDLE->SEND).
- fifo_count, fifo_full and fifo_empty are registered and reflect the state after the last edge. There is no combinational path from rx_byte_valid.
- Ordering: bytes are launched in strict arrival order. No data transformation is applied.

Test Plan:
- Single byte: reset, push 0xA5, transmitter model idle -> tx_byte_valid high for 1 cycle, 2 cycles after the push, with tx_byte_data = 0xA5; fifo_count goes 0->1->0.
- Burst/order: push 0x01..0x05 on consecutive cycles with the transmitter model taking 868x10 cycles per frame -> launches 0x01..0x05 in order, one per tx_done, each launch 2 cycles after tx_done; fifo_count peaks at 4.
- Full/overflow: DEPTH=16, hold tx_active high, push 17 bytes 0x10..0x20 -> fifo_full=1, fifo_count=16, overflow=1, and 0x20 is never transmitted. Then pulse overflow_clr -> overflow=0.
- Simultaneous push/pop when full: with count=16 in IDLE, drop tx_active and push 0x55 in the same cycle as the pop -> count stays 16, overflow stays 0, and 0x55 is the last byte sent.
- Overflow set vs clear: overflow_clr asserted in the same cycle as a dropped push -> overflow=1 afterwards.
- Reset mid-operation: with 3 entries stored and the FSM in BUSY, rst_n low for 1 cycle -> fifo_count=0, fifo_empty=1, tx_byte_valid=0, no further launches; a subsequent push of 0x3C gives a normal launch after 2 cycles.

Source files
------------

// File: rtl/uart_echo_fifo.sv
// Loopback buffer between the UART receiver and transmitter: a circular FIFO
// that launches one byte per idle transmitter, with fill level and sticky overflow.
module uart_echo_fifo #(
  parameter  int PACK_SIZE = 8,
  parameter  int DEPTH     = 16,
  localparam int CW        = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_byte_valid,
  input  logic [PACK_SIZE-1:0] rx_byte_data,
  input  logic                 tx_active,
  input  logic                 tx_done,
  output logic                 tx_byte_valid,
  output logic [PACK_SIZE-1:0] tx_byte_data,
  output logic [CW-1:0]        fifo_count,
  output logic                 fifo_full,
  output logic                 fifo_empty,
  output logic                 overflow,
  input  logic                 overflow_clr
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, SEND, BUSY} state_t;

  state_t               r_state, w_state_nxt;
  logic [PACK_SIZE-1:0] r_mem [DEPTH];
  logic [AW-1:0]        r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]        r_count;
  logic                 r_tx_valid, r_overflow;
  logic [PACK_SIZE-1:0] r_tx_data;
  logic                 w_full, w_empty, w_pop, w_push, w_drop;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (!w_empty && !tx_active) w_state_nxt = SEND;
      SEND:    w_state_nxt = BUSY;
      BUSY:    if (tx_done) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
  always_comb begin
    w_pop  = (r_state == IDLE) && !w_empty && !tx_active;
    w_push = rx_byte_valid && (!w_full || w_pop);
    w_drop = rx_byte_valid && !w_push;
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= rx_byte_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_tx_valid <= w_pop;
      if (w_pop) begin
        r_tx_data <= r_mem[r_rd_ptr];
        r_rd_ptr  <= r_rd_ptr + AW'(1);
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop)            r_overflow <= 1'b1;
      else if (overflow_clr) r_overflow <= 1'b0;
    end
  end

  assign tx_byte_valid = r_tx_valid;
  assign tx_byte_data  = r_tx_data;
  assign fifo_count    = r_count;
  assign fifo_full     = w_full;
  assign fifo_empty    = w_empty;
  assign overflow      = r_overflow;
endmodule
